// File: rtl/blit_engine.sv
`default_nettype none
// ============================================================================
// Module   : blit_engine
// Purpose  : 1-bpp rectangle engine (FILL / COPY / INVERT) that walks a
//            320x200 framebuffer one pixel at a time through RAM port B,
//            clipping off-screen pixels and ordering COPY scans so that
//            overlapping source/destination rectangles copy correctly.
// Revision : 1.0  initial release
// ============================================================================
module blit_engine (
   input  logic       clk_b,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [8:0] cmd_dx,
   input  logic [7:0] cmd_dy,
   input  logic [8:0] cmd_sx,
   input  logic [7:0] cmd_sy,
   input  logic [8:0] cmd_w,
   input  logic [7:0] cmd_h,
   input  logic       cmd_color,
   output logic       busy,
   output logic       done,
   output logic [8:0] mem_x,
   output logic [7:0] mem_y,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_wdata,
   input  logic       mem_rdata,
   input  logic       mem_rdy
);

   localparam logic [1:0] c_OP_FILL   = 2'b00;
   localparam logic [1:0] c_OP_COPY   = 2'b01;
   localparam logic [1:0] c_OP_INVERT = 2'b10;
   localparam logic [1:0] c_OP_RSVD   = 2'b11;
   localparam logic [9:0] c_FB_W      = 10'd320;
   localparam logic [8:0] c_FB_H      = 9'd200;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      WR_REQ  = 3'd4,
      WR_WAIT = 3'd5,
      ADV     = 3'd6,
      FINISH  = 3'd7
   } state_t;

   state_t     r_state;
   logic [1:0] r_op;
   logic [8:0] r_dx;
   logic [7:0] r_dy;
   logic [8:0] r_sx;
   logic [7:0] r_sy;
   logic [8:0] r_w;
   logic [7:0] r_h;
   logic       r_color;
   logic       r_rev;
   logic       r_armed;
   logic       r_rdata;
   logic [8:0] r_col;
   logic [7:0] r_row;

   // Pixel coordinates are formed one bit wider than the inputs so that a
   // rectangle hanging off the right/bottom edge never wraps back on-screen.
   logic [9:0] w_dst_x;
   logic [8:0] w_dst_y;
   logic [9:0] w_src_x;
   logic [8:0] w_src_y;
   logic       w_dst_clip;
   logic       w_src_clip;
   logic       w_skip;
   logic       w_last;
   logic       w_rev;
   state_t     w_pix_start;
   logic [9:0] w_rd_x;
   logic [8:0] w_rd_y;

   assign cmd_ready   = (r_state == IDLE);

   assign w_dst_x     = {1'b0, r_dx} + {1'b0, r_col};
   assign w_dst_y     = {1'b0, r_dy} + {1'b0, r_row};
   assign w_src_x     = {1'b0, r_sx} + {1'b0, r_col};
   assign w_src_y     = {1'b0, r_sy} + {1'b0, r_row};
   assign w_dst_clip  = (w_dst_x >= c_FB_W) || (w_dst_y >= c_FB_H);
   assign w_src_clip  = (w_src_x >= c_FB_W) || (w_src_y >= c_FB_H);
   assign w_skip      = w_dst_clip || ((r_op == c_OP_COPY) && w_src_clip);

   // COPY reads its source, INVERT reads the destination it will overwrite.
   assign w_rd_x      = (r_op == c_OP_COPY) ? w_src_x : w_dst_x;
   assign w_rd_y      = (r_op == c_OP_COPY) ? w_src_y : w_dst_y;

   // Walking backwards when the destination lies after the source keeps
   // every source pixel unread-over until it has been copied.
   assign w_rev       = (r_op == c_OP_COPY) &&
                        ((r_dy > r_sy) || ((r_dy == r_sy) && (r_dx > r_sx)));

   assign w_last      = r_rev ? ((r_col == 9'd0) && (r_row == 8'd0))
                              : ((r_col == r_w - 9'd1) && (r_row == r_h - 8'd1));

   assign w_pix_start = (r_op == c_OP_FILL) ? WR_REQ : RD_REQ;

   // Command sequencer: one pixel read/modify/write at a time, all outputs registered.
   always_ff @(posedge clk_b) begin
      if (reset) begin
         r_state   <= IDLE;
         r_op      <= 2'b00;
         r_dx      <= 9'd0;
         r_dy      <= 8'd0;
         r_sx      <= 9'd0;
         r_sy      <= 8'd0;
         r_w       <= 9'd0;
         r_h       <= 8'd0;
         r_color   <= 1'b0;
         r_rev     <= 1'b0;
         r_armed   <= 1'b0;
         r_rdata   <= 1'b0;
         r_col     <= 9'd0;
         r_row     <= 8'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_x     <= 9'd0;
         mem_y     <= 8'd0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_wdata <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (cmd_valid) begin
                  r_op    <= cmd_op;
                  r_dx    <= cmd_dx;
                  r_dy    <= cmd_dy;
                  r_sx    <= cmd_sx;
                  r_sy    <= cmd_sy;
                  r_w     <= cmd_w;
                  r_h     <= cmd_h;
                  r_color <= cmd_color;
                  busy    <= 1'b1;
                  r_state <= SETUP;
               end
            end
            SETUP: begin
               if ((r_w == 9'd0) || (r_h == 8'd0) || (r_op == c_OP_RSVD)) begin
                  done    <= 1'b1;
                  r_state <= FINISH;
               end else begin
                  r_rev   <= w_rev;
                  r_col   <= w_rev ? (r_w - 9'd1) : 9'd0;
                  r_row   <= w_rev ? (r_h - 8'd1) : 8'd0;
                  r_state <= w_pix_start;
               end
            end
            RD_REQ: begin
               if (w_skip) begin
                  r_state <= ADV;
               end else if (mem_rdy) begin
                  mem_read <= 1'b1;
                  mem_x    <= w_rd_x[8:0];
                  mem_y    <= w_rd_y[7:0];
                  r_armed  <= 1'b0;
                  r_state  <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               // mem_rdy is stale during the strobe and the cycle after it.
               mem_read <= 1'b0;
               if (!mem_read) begin
                  if (!r_armed) begin
                     r_armed <= 1'b1;
                  end else if (mem_rdy) begin
                     r_rdata <= mem_rdata;
                     r_state <= WR_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (w_skip) begin
                  r_state <= ADV;
               end else if (mem_rdy) begin
                  mem_write <= 1'b1;
                  mem_x     <= w_dst_x[8:0];
                  mem_y     <= w_dst_y[7:0];
                  case (r_op)
                     c_OP_COPY:   mem_wdata <= r_rdata;
                     c_OP_INVERT: mem_wdata <= ~r_rdata;
                     default:     mem_wdata <= r_color;
                  endcase
                  r_armed   <= 1'b0;
                  r_state   <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               mem_write <= 1'b0;
               if (!mem_write) begin
                  if (!r_armed) begin
                     r_armed <= 1'b1;
                  end else if (mem_rdy) begin
                     r_state <= ADV;
                  end
               end
            end
            ADV: begin
               if (w_last) begin
                  done    <= 1'b1;
                  r_state <= FINISH;
               end else begin
                  if (r_rev) begin
                     if (r_col == 9'd0) begin
                        r_col <= r_w - 9'd1;
                        r_row <= r_row - 8'd1;
                     end else begin
                        r_col <= r_col - 9'd1;
                     end
                  end else begin
                     if (r_col == r_w - 9'd1) begin
                        r_col <= 9'd0;
                        r_row <= r_row + 8'd1;
                     end else begin
                        r_col <= r_col + 9'd1;
                     end
                  end
                  r_state <= w_pix_start;
               end
            end
            FINISH: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_blit_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_blit_engine
// Purpose  : Scoreboard bench for blit_engine with a behavioural framebuffer
//            RAM model (two-cycle busy after each strobe, optional stall).
// Revision : 1.0  initial release
// ============================================================================
module tb_blit_engine;

   logic       clk_b = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [8:0] cmd_dx = 9'd0;
   logic [7:0] cmd_dy = 8'd0;
   logic [8:0] cmd_sx = 9'd0;
   logic [7:0] cmd_sy = 8'd0;
   logic [8:0] cmd_w = 9'd0;
   logic [7:0] cmd_h = 8'd0;
   logic       cmd_color = 1'b0;
   logic       busy;
   logic       done;
   logic [8:0] mem_x;
   logic [7:0] mem_y;
   logic       mem_read;
   logic       mem_write;
   logic       mem_wdata;
   logic       mem_rdata;
   logic       mem_rdy;

   blit_engine dut (
      .clk_b     (clk_b),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_dx    (cmd_dx),
      .cmd_dy    (cmd_dy),
      .cmd_sx    (cmd_sx),
      .cmd_sy    (cmd_sy),
      .cmd_w     (cmd_w),
      .cmd_h     (cmd_h),
      .cmd_color (cmd_color),
      .busy      (busy),
      .done      (done),
      .mem_x     (mem_x),
      .mem_y     (mem_y),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy)
   );

   always #5 clk_b = ~clk_b;

   int cyc = 0;
   always @(posedge clk_b) cyc <= cyc + 1;

   // ---------------- framebuffer RAM model ----------------
   bit   fb [0:63999];
   int   ram_cnt = 0;
   logic ram_rdy_q = 1'b1;
   logic ram_rdata_q = 1'b0;
   logic stall = 1'b0;
   logic poke_en = 1'b0;
   int   poke_idx = 0;
   bit   poke_val = 1'b0;

   assign mem_rdy   = ram_rdy_q && !stall;
   assign mem_rdata = ram_rdata_q;

   // RAM shares reset, so a strobe in a reset cycle is ignored.
   always @(posedge clk_b) begin
      if (reset) begin
         ram_cnt   <= 0;
         ram_rdy_q <= 1'b1;
      end else if (mem_read || mem_write) begin
         if (mem_write) fb[int'(mem_y) * 320 + int'(mem_x)] <= mem_wdata;
         else           ram_rdata_q <= fb[int'(mem_y) * 320 + int'(mem_x)];
         ram_cnt   <= 2;
         ram_rdy_q <= 1'b0;
      end else if (ram_cnt > 0) begin
         ram_cnt   <= ram_cnt - 1;
         ram_rdy_q <= (ram_cnt == 1);
      end
      if (poke_en) fb[poke_idx] <= poke_val;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int kind;   // 0 read, 1 write, 2 done
      int x;
      int y;
      int d;
   } exp_t;

   exp_t exp_q [$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   wr_count = 0;
   int   strobe_count = 0;
   int   done_count = 0;
   int   done_cyc = 0;
   int   acc_cyc = 0;
   logic prev_strobe = 1'b0;
   logic prev_rdy = 1'b1;
   logic started = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic exp_rd(input int x, input int y);
      exp_q.push_back('{0, x, y, 0});
   endtask

   task automatic exp_wr(input int x, input int y, input int d);
      exp_q.push_back('{1, x, y, d});
   endtask

   task automatic exp_done();
      exp_q.push_back('{2, 0, 0, 0});
   endtask

   // Monitor: every strobe or done pulse pops and checks the next expectation.
   always @(negedge clk_b) begin
      if (!reset && started) begin
         if (mem_read && mem_write) chk("rd_wr_together", 1, 0);
         if (mem_read || mem_write) begin
            strobe_count++;
            chk("strobe_width", int'(prev_strobe), 0);
            chk("strobe_after_rdy", int'(prev_rdy), 1);
            chk("outstanding", ram_cnt, 0);
            if (mem_write) wr_count++;
            chk("strobe_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("strobe_kind", mem_write ? 1 : 0, mon_e.kind);
               chk("mem_x", int'(mem_x), mon_e.x);
               chk("mem_y", int'(mem_y), mon_e.y);
               if (mem_write) chk("mem_wdata", int'(mem_wdata), mon_e.d);
            end
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
            chk("done_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("done_kind", 2, mon_e.kind);
            end
         end
      end
      prev_strobe <= mem_read || mem_write;
      prev_rdy    <= mem_rdy;
   end

   // ---------------- stimulus ----------------
   task automatic poke(input int x, input int y, input bit v);
      @(negedge clk_b);
      poke_en  = 1'b1;
      poke_idx = y * 320 + x;
      poke_val = v;
      @(posedge clk_b);
      #1 poke_en = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input int dx, input int dy,
                        input int sx, input int sy, input int w, input int h,
                        input logic color);
      @(negedge clk_b);
      chk("cmd_ready_idle", int'(cmd_ready), 1);
      cmd_op    = op;
      cmd_dx    = dx[8:0];
      cmd_dy    = dy[7:0];
      cmd_sx    = sx[8:0];
      cmd_sy    = sy[7:0];
      cmd_w     = w[8:0];
      cmd_h     = h[7:0];
      cmd_color = color;
      cmd_valid = 1'b1;
      acc_cyc   = cyc;
      @(posedge clk_b);
      #1;
      cmd_valid = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk_b);
         #1;
         n++;
      end
      chk({name, "_timeout"}, int'(n < 2000), 1);
      chk({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int base;
      int n;
      int dcount;

      repeat (3) @(posedge clk_b);
      #1 reset = 1'b0;
      started = 1'b1;
      @(negedge clk_b);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_mem_read", int'(mem_read), 0);
      chk("rst_mem_write", int'(mem_write), 0);
      chk("rst_mem_wdata", int'(mem_wdata), 0);
      chk("rst_mem_x", int'(mem_x), 0);
      chk("rst_mem_y", int'(mem_y), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);

      // FILL 3x2 at (10,5)
      exp_wr(10, 5, 1); exp_wr(11, 5, 1); exp_wr(12, 5, 1);
      exp_wr(10, 6, 1); exp_wr(11, 6, 1); exp_wr(12, 6, 1);
      exp_done();
      dcount = done_count;
      issue(2'b00, 10, 5, 0, 0, 3, 2, 1'b1);
      wait_idle("fill");
      chk("fill_done_count", done_count - dcount, 1);
      for (int y = 5; y <= 6; y++)
         for (int x = 10; x <= 12; x++)
            chk("fill_pixel", int'(fb[y * 320 + x]), 1);

      // Overlapping COPY right by one: reverse order expected
      poke(0, 0, 1'b1); poke(1, 0, 1'b0); poke(2, 0, 1'b1);
      poke(3, 0, 1'b1); poke(4, 0, 1'b0);
      exp_rd(3, 0); exp_wr(4, 0, 1);
      exp_rd(2, 0); exp_wr(3, 0, 1);
      exp_rd(1, 0); exp_wr(2, 0, 0);
      exp_rd(0, 0); exp_wr(1, 0, 1);
      exp_done();
      issue(2'b01, 1, 0, 0, 0, 4, 1, 1'b0);
      wait_idle("copy");
      chk("copy_px0", int'(fb[0]), 1);
      chk("copy_px1", int'(fb[1]), 1);
      chk("copy_px2", int'(fb[2]), 0);
      chk("copy_px3", int'(fb[3]), 1);
      chk("copy_px4", int'(fb[4]), 1);

      // INVERT clipped at the bottom-right corner
      poke(318, 199, 1'b0); poke(319, 199, 1'b1);
      exp_rd(318, 199); exp_wr(318, 199, 1);
      exp_rd(319, 199); exp_wr(319, 199, 0);
      exp_done();
      issue(2'b10, 318, 199, 0, 0, 4, 3, 1'b0);
      wait_idle("invert");
      chk("invert_px318", int'(fb[199 * 320 + 318]), 1);
      chk("invert_px319", int'(fb[199 * 320 + 319]), 0);

      // Zero width: done after two cycles, no memory access
      base = strobe_count;
      exp_done();
      issue(2'b00, 50, 50, 0, 0, 0, 4, 1'b1);
      wait_idle("w0");
      chk("w0_latency", done_cyc - acc_cyc, 2);
      chk("w0_no_strobe", strobe_count - base, 0);

      // Reserved op: same behaviour
      base = strobe_count;
      exp_done();
      issue(2'b11, 60, 60, 0, 0, 2, 2, 1'b1);
      wait_idle("op3");
      chk("op3_latency", done_cyc - acc_cyc, 2);
      chk("op3_no_strobe", strobe_count - base, 0);

      // RAM stalled for seven cycles before the only request
      base = wr_count;
      exp_wr(0, 10, 1);
      exp_done();
      stall = 1'b1;
      issue(2'b00, 0, 10, 0, 0, 1, 1, 1'b1);
      repeat (6) @(posedge clk_b);
      #1;
      chk("stall_no_write", wr_count - base, 0);
      stall = 1'b0;
      wait_idle("stall");
      chk("stall_one_write", wr_count - base, 1);
      chk("stall_pixel", int'(fb[10 * 320 + 0]), 1);

      // Reset while the third pixel of a FILL is being written
      base   = wr_count;
      dcount = done_count;
      exp_wr(20, 20, 1); exp_wr(21, 20, 1); exp_wr(22, 20, 1);
      issue(2'b00, 20, 20, 0, 0, 4, 1, 1'b1);
      n = 0;
      while (wr_count - base < 3 && n < 500) begin
         @(negedge clk_b);
         #1;
         n++;
      end
      chk("rst_mid_timeout", int'(n < 500), 1);
      reset = 1'b1;
      repeat (2) @(posedge clk_b);
      #1 reset = 1'b0;
      @(negedge clk_b);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_ready", int'(cmd_ready), 1);
      chk("rst_mid_strobe", int'(mem_read || mem_write), 0);
      chk("rst_mid_queue", exp_q.size(), 0);
      repeat (4) @(negedge clk_b);
      chk("rst_mid_no_done", done_count - dcount, 0);
      chk("rst_mid_dropped_write", int'(fb[20 * 320 + 22]), 0);
      chk("rst_mid_first_write", int'(fb[20 * 320 + 20]), 1);

      // Following FILL completes normally
      exp_wr(30, 30, 1); exp_wr(31, 30, 1);
      exp_done();
      issue(2'b00, 30, 30, 0, 0, 2, 1, 1'b1);
      wait_idle("after_rst");
      chk("after_rst_done", done_count - dcount, 1);
      chk("after_rst_px", int'(fb[30 * 320 + 31]), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
